// File: rtl/cp0_unit.sv
// CP0 system-control coprocessor: Status, Cause, EPC, BadVAddr, Count and
// Compare, with exception/ERET sequencing and interrupt request generation.
module cp0_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception_triggered,
    input  logic        cp0_write_enable,
    input  logic [4:0]  final_exception_type,
    input  logic [31:0] epc_in,
    input  logic [31:0] badvaddr_in,
    input  logic        eret,
    input  logic        mtc0_en,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    input  logic [4:0]  hw_int,
    output logic [31:0] mfc0_rdata,
    output logic [31:0] cp0_epc,
    output logic        status_exl,
    output logic        status_ie,
    output logic        int_request
);

    localparam logic [4:0] AddrBadVAddr = 5'd8;
    localparam logic [4:0] AddrCount    = 5'd9;
    localparam logic [4:0] AddrCompare  = 5'd11;
    localparam logic [4:0] AddrStatus   = 5'd12;
    localparam logic [4:0] AddrCause    = 5'd13;
    localparam logic [4:0] AddrEpc      = 5'd14;

    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;

    // Status fields (BEV is a constant and not stored)
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;

    // Cause fields; IP[15] is TI, IP[14:10] sample hw_int, IP[9:8] are software
    logic        r_ti;
    logic [4:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;

    logic        w_exc_accept;
    logic        w_eret_take;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_count_inc;
    logic        w_count_match;
    logic        w_badv_load;
    logic [31:0] w_count_plus1;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [7:0]  w_ip;

    // Event decode: exception outranks ERET, which outranks MTC0 on Status/Cause/EPC
    assign w_exc_accept  = exception_triggered & cp0_write_enable;
    assign w_eret_take   = eret & ~w_exc_accept;
    assign w_wr_count    = mtc0_en & (mtc0_addr == AddrCount);
    assign w_wr_compare  = mtc0_en & (mtc0_addr == AddrCompare);
    assign w_wr_status   = mtc0_en & (mtc0_addr == AddrStatus) & ~w_exc_accept & ~eret;
    assign w_wr_cause    = mtc0_en & (mtc0_addr == AddrCause) & ~w_exc_accept;
    assign w_wr_epc      = mtc0_en & (mtc0_addr == AddrEpc) & ~w_exc_accept;
    assign w_badv_load   = w_exc_accept &
                           ((final_exception_type == ExcAdEL) |
                            (final_exception_type == ExcAdES));

    // Count advances on every other edge; an MTC0 load suppresses the increment
    assign w_count_plus1 = r_count + 32'd1;
    assign w_count_inc   = r_toggle & ~w_wr_count;
    assign w_count_match = w_count_inc & (w_count_plus1 == r_compare);

    // Architectural register images as seen by MFC0
    assign w_ip     = {r_ti, r_ip_hw, r_ip_sw};
    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {1'b0, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

    assign cp0_epc     = r_epc;
    assign status_exl  = r_exl;
    assign status_ie   = r_ie;
    assign int_request = r_ie & ~r_exl & (|(w_ip & r_im));

    // Status: exception sets EXL, ERET clears it, MTC0 loads the writable bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im  <= 8'd0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_exc_accept) begin
            r_exl <= 1'b1;
        end else if (w_eret_take) begin
            r_exl <= 1'b0;
        end else if (w_wr_status) begin
            r_im  <= mtc0_wdata[15:8];
            r_exl <= mtc0_wdata[1];
            r_ie  <= mtc0_wdata[0];
        end
    end

    // Cause: ExcCode on exception, software IP via MTC0, hardware IP sampled each cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ip_hw   <= 5'd0;
            r_ip_sw   <= 2'd0;
            r_exccode <= 5'd0;
        end else begin
            r_ip_hw <= hw_int;
            if (w_exc_accept) begin
                r_exccode <= final_exception_type;
            end else if (w_wr_cause) begin
                r_ip_sw <= mtc0_wdata[9:8];
            end
        end
    end

    // EPC only captures when not already in exception level, so nested faults keep it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc <= 32'd0;
        end else if (w_exc_accept) begin
            if (!r_exl) begin
                r_epc <= epc_in;
            end
        end else if (w_wr_epc) begin
            r_epc <= mtc0_wdata;
        end
    end

    // BadVAddr records the faulting address for address-error exceptions only
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_badvaddr <= 32'd0;
        end else if (w_badv_load) begin
            r_badvaddr <= badvaddr_in;
        end
    end

    // Count and its half-rate toggle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_toggle <= 1'b0;
            r_count  <= 32'd0;
        end else begin
            r_toggle <= ~r_toggle;
            if (w_wr_count) begin
                r_count <= mtc0_wdata;
            end else if (w_count_inc) begin
                r_count <= w_count_plus1;
            end
        end
    end

    // Compare and timer interrupt; a Compare write beats a same-cycle match
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare <= mtc0_wdata;
            r_ti      <= 1'b0;
        end else if (w_count_match) begin
            r_ti      <= 1'b1;
        end
    end

    // MFC0 read mux from registered state only
    always_comb begin
        mfc0_rdata = 32'd0;
        case (mfc0_addr)
            AddrBadVAddr: mfc0_rdata = r_badvaddr;
            AddrCount:    mfc0_rdata = r_count;
            AddrCompare:  mfc0_rdata = r_compare;
            AddrStatus:   mfc0_rdata = w_status;
            AddrCause:    mfc0_rdata = w_cause;
            AddrEpc:      mfc0_rdata = r_epc;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

endmodule
